// File: rtl/pkmc_sdram_refresh_seq_pkg.sv
// Shared SDRAM refresh definitions: command encodings,
// timing defaults and sequencer state encoding.
package pkmc_sdram_refresh_seq_pkg;

  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_REF = 3'b001;

  localparam int DEF_T_RP      = 2;
  localparam int DEF_T_RFC     = 7;
  localparam int DEF_INIT_REFS = 8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IDLE,
    PRE,
    WAIT_RP,
    REF,
    WAIT_RFC,
    DONE,
    GUARD_ST
  } state_t;

  // Command cycle plus zero-flag cycle consume two of the n cycles.
  function automatic logic [3:0] spacing_ld(input int n);
    return (n >= 2) ? 4'(n - 2) : 4'd0;
  endfunction

endpackage

// File: rtl/pkmc_sdram_timer.sv
// Loadable 4-bit down-counter with zero flag; used for
// precharge, refresh and guard spacing.
module pkmc_sdram_timer (
  input  logic       clk,
  input  logic       syncRst,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] cnt;

  always_ff @(posedge clk or posedge syncRst) begin
    if (syncRst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/pkmc_sdram_refresh_seq.sv
// SDRAM refresh/init sequencer: waits for the bus, precharges
// all banks, issues one or INIT_REFS auto-refreshes, then guards.
module pkmc_sdram_refresh_seq
  import pkmc_sdram_refresh_seq_pkg::*;
#(
  parameter int T_RP      = DEF_T_RP,
  parameter int T_RFC     = DEF_T_RFC,
  parameter int INIT_REFS = DEF_INIT_REFS,
  parameter int GUARD     = 2,
  parameter int MAX_WAIT  = 63
) (
  input  logic       clk,
  input  logic       syncRst,
  input  logic       ref_req,
  input  logic       init_start,
  input  logic       bus_busy,
  output logic       ref_hold,
  output logic       cs_n,
  output logic [2:0] cmd_n,
  output logic       a10,
  output logic       ref_done,
  output logic       init_done,
  output logic       ref_late
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [3:0] RP_LD = spacing_ld(T_RP);
  localparam logic [3:0] RFC_LD = spacing_ld(T_RFC);
  localparam logic [3:0] GD_LD = spacing_ld(GUARD + 1);

  state_t state;
  state_t nxt;

  logic          init_mode;
  logic [3:0]    ref_cnt;
  logic [3:0]    tgt;
  logic [WW-1:0] wait_cnt;
  logic          tmr_load;
  logic [3:0]    tmr_val;
  logic          tmr_zero;

  pkmc_sdram_timer u_timer (
    .clk      (clk),
    .syncRst  (syncRst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  assign tgt = init_mode ? 4'(INIT_REFS) : 4'd1;

  always_ff @(posedge clk or posedge syncRst) begin
    if (syncRst) begin
      state     <= IDLE;
      init_mode <= 1'b0;
      init_done <= 1'b0;
      ref_late  <= 1'b0;
      ref_cnt   <= '0;
      wait_cnt  <= '0;
    end else begin
      state <= nxt;
      if ((state == IDLE || state == GUARD_ST) &&
          nxt == WAIT_IDLE) begin
        init_mode <= init_start;
      end
      if (state == DONE && init_mode) begin
        init_done <= 1'b1;
      end
      if (state == WAIT_IDLE) begin
        ref_cnt <= '0;
      end else if (state == REF) begin
        ref_cnt <= ref_cnt + 4'd1;
      end
      if (state != WAIT_IDLE) begin
        wait_cnt <= '0;
      end else if (bus_busy) begin
        if (wait_cnt != WW'(MAX_WAIT)) begin
          wait_cnt <= wait_cnt + 1'b1;
        end
        if (wait_cnt == WW'(MAX_WAIT - 1)) begin
          ref_late <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    nxt      = state;
    tmr_load = 1'b0;
    tmr_val  = '0;
    ref_hold = 1'b1;
    cs_n     = 1'b0;
    cmd_n    = CMD_NOP;
    a10      = 1'b0;
    ref_done = 1'b0;
    unique case (state)
      IDLE: begin
        ref_hold = 1'b0;
        cs_n     = 1'b1;
        if (init_start || ref_req) nxt = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (!bus_busy) nxt = PRE;
      end
      PRE: begin
        cmd_n    = CMD_PRE;
        a10      = 1'b1;
        tmr_load = 1'b1;
        tmr_val  = RP_LD;
        nxt      = (T_RP == 1) ? REF : WAIT_RP;
      end
      WAIT_RP: begin
        if (tmr_zero) nxt = REF;
      end
      REF: begin
        cmd_n    = CMD_REF;
        tmr_load = 1'b1;
        tmr_val  = RFC_LD;
        nxt      = WAIT_RFC;
      end
      WAIT_RFC: begin
        if (tmr_zero) begin
          nxt = (ref_cnt == tgt) ? DONE : REF;
        end
      end
      DONE: begin
        ref_done = 1'b1;
        tmr_load = 1'b1;
        tmr_val  = GD_LD;
        nxt      = (GUARD == 0) ? IDLE : GUARD_ST;
      end
      GUARD_ST: begin
        ref_hold = 1'b0;
        cs_n     = 1'b1;
        if (init_start) nxt = WAIT_IDLE;
        else if (tmr_zero) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pkmc_sdram_refresh_seq.sv
// Directed bench for the SDRAM refresh sequencer with
// hand-derived cycle timings at default parameters.
module tb_pkmc_sdram_refresh_seq;

  logic       clk;
  logic       syncRst;
  logic       ref_req;
  logic       init_start;
  logic       bus_busy;
  logic       ref_hold;
  logic       cs_n;
  logic [2:0] cmd_n;
  logic       a10;
  logic       ref_done;
  logic       init_done;
  logic       ref_late;

  int errors;
  int checks;

  localparam logic [6:0] V_IDLE = 7'b0_1_111_0_0;
  localparam logic [6:0] V_NOP  = 7'b1_0_111_0_0;
  localparam logic [6:0] V_PRE  = 7'b1_0_010_1_0;
  localparam logic [6:0] V_REF  = 7'b1_0_001_0_0;
  localparam logic [6:0] V_DONE = 7'b1_0_111_0_1;

  pkmc_sdram_refresh_seq dut (
    .clk        (clk),
    .syncRst    (syncRst),
    .ref_req    (ref_req),
    .init_start (init_start),
    .bus_busy   (bus_busy),
    .ref_hold   (ref_hold),
    .cs_n       (cs_n),
    .cmd_n      (cmd_n),
    .a10        (a10),
    .ref_done   (ref_done),
    .init_done  (init_done),
    .ref_late   (ref_late)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] outv();
    return {ref_hold, cs_n, cmd_n, a10, ref_done};
  endfunction

  function automatic logic is_cmd(input logic [2:0] c);
    return (!cs_n && cmd_n == c);
  endfunction

  task automatic do_reset();
    syncRst    = 1'b1;
    ref_req    = 1'b0;
    init_start = 1'b0;
    bus_busy   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    syncRst = 1'b0;
  endtask

  task automatic test_reset();
    syncRst = 1'b1;
    ref_req = 1'b0;
    init_start = 1'b0;
    bus_busy = 1'b0;
    @(negedge clk);
    checks += 7;
    if (ref_hold !== 1'b0) begin
      errors++;
      $display("FAIL rst_hold got=%b exp=0", ref_hold);
    end
    if (cs_n !== 1'b1) begin
      errors++;
      $display("FAIL rst_cs_n got=%b exp=1", cs_n);
    end
    if (cmd_n !== 3'b111) begin
      errors++;
      $display("FAIL rst_cmd got=%b exp=111", cmd_n);
    end
    if (a10 !== 1'b0) begin
      errors++;
      $display("FAIL rst_a10 got=%b exp=0", a10);
    end
    if (ref_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_done got=%b exp=0", ref_done);
    end
    if (init_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_init_done got=%b exp=0", init_done);
    end
    if (ref_late !== 1'b0) begin
      errors++;
      $display("FAIL rst_late got=%b exp=0", ref_late);
    end
  endtask

  task automatic test_single_ref();
    logic [6:0] exp;
    do_reset();
    ref_req = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c == 0 || c >= 12) exp = V_IDLE;
      else if (c == 2) exp = V_PRE;
      else if (c == 4) exp = V_REF;
      else if (c == 11) exp = V_DONE;
      else exp = V_NOP;
      checks++;
      if (outv() !== exp) begin
        errors++;
        $display("FAIL single c=%0d got=%b exp=%b",
                 c, outv(), exp);
      end
      if (c == 11) ref_req = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_init();
    int nref, npre, ndone, first, last, bad, done_at;
    logic id60;
    nref = 0; npre = 0; ndone = 0;
    first = -1; last = -1; bad = 0; done_at = -1;
    id60 = 1'bx;
    do_reset();
    init_start = 1'b1;
    for (int c = 0; c < 66; c++) begin
      if (c == 1) init_start = 1'b0;
      if (is_cmd(3'b001)) begin
        if (first < 0) first = c;
        else if (c - last != 7) bad++;
        last = c;
        nref++;
      end
      if (is_cmd(3'b010)) npre++;
      if (ref_done) begin
        ndone++;
        done_at = c;
      end
      if (c == 60) id60 = init_done;
      @(negedge clk);
    end
    checks += 7;
    if (nref !== 8) begin
      errors++;
      $display("FAIL init_nref got=%0d exp=8", nref);
    end
    if (npre !== 1) begin
      errors++;
      $display("FAIL init_npre got=%0d exp=1", npre);
    end
    if (first !== 4) begin
      errors++;
      $display("FAIL init_first got=%0d exp=4", first);
    end
    if (bad !== 0) begin
      errors++;
      $display("FAIL init_gap bad=%0d exp=0", bad);
    end
    if (done_at !== 60 || ndone !== 1) begin
      errors++;
      $display("FAIL init_done_at got=%0d n=%0d exp=60 n=1",
               done_at, ndone);
    end
    if (id60 !== 1'b0) begin
      errors++;
      $display("FAIL init_done_early got=%b exp=0", id60);
    end
    if (init_done !== 1'b1) begin
      errors++;
      $display("FAIL init_done_set got=%b exp=1", init_done);
    end
  endtask

  task automatic test_late();
    int hold_low, done_at;
    logic l63, l64;
    logic [2:0] c70, c71;
    hold_low = 0; done_at = -1;
    l63 = 1'bx; l64 = 1'bx; c70 = 'x; c71 = 'x;
    do_reset();
    ref_req = 1'b1;
    bus_busy = 1'b1;
    for (int c = 0; c < 86; c++) begin
      if (c == 70) bus_busy = 1'b0;
      if (c >= 1 && c <= 70 && !ref_hold) hold_low++;
      if (c == 63) l63 = ref_late;
      if (c == 64) l64 = ref_late;
      if (c == 70) c70 = cmd_n;
      if (c == 71) c71 = cmd_n;
      if (ref_done) begin
        done_at = c;
        ref_req = 1'b0;
      end
      @(negedge clk);
    end
    checks += 7;
    if (hold_low !== 0) begin
      errors++;
      $display("FAIL late_hold low=%0d exp=0", hold_low);
    end
    if (l63 !== 1'b0) begin
      errors++;
      $display("FAIL late_63 got=%b exp=0", l63);
    end
    if (l64 !== 1'b1) begin
      errors++;
      $display("FAIL late_64 got=%b exp=1", l64);
    end
    if (c70 !== 3'b111) begin
      errors++;
      $display("FAIL late_c70 got=%b exp=111", c70);
    end
    if (c71 !== 3'b010) begin
      errors++;
      $display("FAIL late_pre got=%b exp=010", c71);
    end
    if (done_at !== 80) begin
      errors++;
      $display("FAIL late_done got=%0d exp=80", done_at);
    end
    if (ref_late !== 1'b1) begin
      errors++;
      $display("FAIL late_sticky got=%b exp=1", ref_late);
    end
  endtask

  task automatic test_guard();
    logic [3:0] hv;
    logic [2:0] c16;
    logic id12;
    int first_done, ndone;
    hv = 'x; c16 = 'x; id12 = 1'bx;
    first_done = -1; ndone = 0;
    do_reset();
    ref_req = 1'b1;
    for (int c = 0; c < 31; c++) begin
      if (c == 6) init_start = 1'b1;
      if (c == 7) init_start = 1'b0;
      if (c == 17) ref_req = 1'b0;
      if (c >= 12 && c <= 15) hv[15 - c] = ref_hold;
      if (c == 16) c16 = cmd_n;
      if (c == 12) id12 = init_done;
      if (ref_done) begin
        if (first_done < 0) first_done = c;
        ndone++;
      end
      @(negedge clk);
    end
    checks += 5;
    if (hv !== 4'b0001) begin
      errors++;
      $display("FAIL guard_hold got=%b exp=0001", hv);
    end
    if (c16 !== 3'b010) begin
      errors++;
      $display("FAIL guard_pre got=%b exp=010", c16);
    end
    if (first_done !== 11) begin
      errors++;
      $display("FAIL guard_first got=%0d exp=11", first_done);
    end
    if (id12 !== 1'b0) begin
      errors++;
      $display("FAIL guard_no_init got=%b exp=0", id12);
    end
    if (ndone !== 2) begin
      errors++;
      $display("FAIL guard_ndone got=%0d exp=2", ndone);
    end
  endtask

  task automatic test_reset_mid();
    logic h7;
    logic [6:0] v;
    int ndone, nhold;
    ndone = 0; nhold = 0;
    do_reset();
    ref_req = 1'b1;
    for (int c = 0; c < 7; c++) @(negedge clk);
    h7 = ref_hold;
    #1 syncRst = 1'b1;
    ref_req = 1'b0;
    #1 v = outv();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (ref_done) ndone++;
    end
    syncRst = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (ref_done) ndone++;
      if (ref_hold) nhold++;
    end
    checks += 4;
    if (h7 !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre_hold got=%b exp=1", h7);
    end
    if (v !== V_IDLE) begin
      errors++;
      $display("FAIL mid_async got=%b exp=%b", v, V_IDLE);
    end
    if (ndone !== 0) begin
      errors++;
      $display("FAIL mid_no_done got=%0d exp=0", ndone);
    end
    if (nhold !== 0) begin
      errors++;
      $display("FAIL mid_idle_hold got=%0d exp=0", nhold);
    end
  endtask

  task automatic test_both();
    int nref, ndone, done_at;
    nref = 0; ndone = 0; done_at = -1;
    do_reset();
    init_start = 1'b1;
    ref_req = 1'b1;
    for (int c = 0; c < 66; c++) begin
      if (c == 1) init_start = 1'b0;
      if (is_cmd(3'b001)) nref++;
      if (ref_done) begin
        ndone++;
        done_at = c;
        ref_req = 1'b0;
      end
      @(negedge clk);
    end
    checks += 3;
    if (nref !== 8) begin
      errors++;
      $display("FAIL both_nref got=%0d exp=8", nref);
    end
    if (ndone !== 1 || done_at !== 60) begin
      errors++;
      $display("FAIL both_done n=%0d at=%0d exp n=1 at=60",
               ndone, done_at);
    end
    if (init_done !== 1'b1) begin
      errors++;
      $display("FAIL both_init_done got=%b exp=1", init_done);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single_ref();
    test_init();
    test_late();
    test_guard();
    test_reset_mid();
    test_both();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pkmc_sdram_refresh_seq.md
PKMC_SDRAM_REFRESH_SEQ -- requirements
Module: pkmc_sdram_refresh_seq

Interface
REQ-001 Parameter T_RP, default 2: precharge-to-refresh spacing in clk cycles, legal 1..15.
REQ-002 Parameter T_RFC, default 7: refresh-to-next-command spacing in clk cycles, legal 2..15.
REQ-003 Parameter INIT_REFS, default 8: auto-refresh commands in an init sequence, legal 1..15.
REQ-004 Parameter GUARD, default 2: cycles after ref_done during which ref_req is ignored.
REQ-005 Parameter MAX_WAIT, default 63: WAIT_IDLE cycles tolerated before ref_late is set.
REQ-006 Reset is syncRst, asynchronous, active-high; the clock is clk.
REQ-007 clk  in  1  system clock.
REQ-008 syncRst  in  1  asynchronous active-high reset.
REQ-009 ref_req  in  1  sticky refresh request from the refresh counter.
REQ-010 init_start  in  1  one-cycle pulse requesting the power-up init sequence.
REQ-011 bus_busy  in  1  main controller is mid-access and owns the SDRAM command bus.
REQ-012 ref_hold  out  1  sequencer requests or owns the bus; controller must not start new accesses.
REQ-013 cs_n  out  1  SDRAM chip select, active low.
REQ-014 cmd_n  out  3  {RAS_n,CAS_n,WE_n}.
REQ-015 a10  out  1  precharge-all select.
REQ-016 ref_done  out  1  one-cycle pulse on sequence completion; clears the upstream counter.
REQ-017 init_done  out  1  sticky; set when the first init sequence completes.
REQ-018 ref_late  out  1  sticky; bus not released within MAX_WAIT cycles.

Function
REQ-019 States: IDLE, WAIT_IDLE, PRE, WAIT_RP, REF, WAIT_RFC, DONE, GUARD_ST.
REQ-020 IDLE: init_start=1 or ref_req=1 -> WAIT_IDLE next cycle; init_start wins when both are high and latches init mode.
REQ-021 ref_hold = 1 in every state except IDLE and GUARD_ST.
REQ-022 WAIT_IDLE: bus_busy=0 -> PRE; else stay and increment the wait counter.
REQ-023 Wait counter reaching MAX_WAIT sets ref_late; the sequence still proceeds when the bus frees.
REQ-024 PRE (1 cycle): cs_n=0, cmd_n=3'b010, a10=1.
REQ-025 REF is entered exactly T_RP cycles after PRE.
REQ-026 REF (1 cycle): cs_n=0, cmd_n=3'b001, a10=0.
REQ-027 Each REF is followed by T_RFC cycles (REF cycle counted) before the next REF or DONE.
REQ-028 Refresh count per sequence: 1 in normal mode, INIT_REFS in init mode.
REQ-029 All non-command cycles drive cs_n=0, cmd_n=3'b111 (NOP), a10=0 while ref_hold=1; in IDLE/GUARD_ST drive cs_n=1, cmd_n=3'b111, a10=0.
REQ-030 DONE (1 cycle): ref_done=1; set init_done if in init mode; -> GUARD_ST.
REQ-031 GUARD_ST lasts GUARD cycles, ignores ref_req, accepts init_start; then -> IDLE.
REQ-032 ref_req or init_start arriving mid-sequence is ignored; init_start is not queued.
REQ-033 bus_busy is sampled only in WAIT_IDLE.
REQ-034 Timer and refresh counters are 4 bits wide; no wrap is permitted within the legal parameter ranges.

Reset
REQ-035 syncRst=1 asynchronously forces IDLE, zeroes all counters, and clears init mode, init_done, and ref_late.
REQ-036 Reset outputs: ref_hold=0, cs_n=1, cmd_n=3'b111, a10=0, ref_done=0, init_done=0, ref_late=0.
REQ-037 Reset mid-sequence aborts the sequence with no ref_done pulse; the upstream counter recovers via its own reset.

Structure
REQ-038 The shared pkmc_sdram_defines include holds the command encodings (NOP, PRECHARGE, AUTO_REFRESH) and the T_RP/T_RFC/INIT_REFS defaults.
REQ-039 One sub-module, pkmc_sdram_timer: loadable 4-bit down-counter with a zero flag, used for both T_RP and T_RFC spacing.

Verification
REQ-040 ref_req=1 from cycle 0, bus_busy=0, defaults -> PRE at cycle 2, REF at cycle 4, ref_done at cycle 11, ref_hold low from cycle 12 to 13.
REQ-041 init_start pulse at cycle 0 -> 8 REF commands spaced 7 cycles apart, one PRE before them, init_done=1 after DONE.
REQ-042 ref_req=1 with bus_busy=1 for 70 cycles -> ref_hold high throughout, ref_late=1 at wait cycle 63, PRE on the cycle after bus_busy falls.
REQ-043 ref_req held high through the GUARD window -> no second sequence starts until GUARD_ST exits; a sequence starts if ref_req is still high in IDLE.
REQ-044 syncRst asserted in WAIT_RFC -> all outputs reach reset values immediately; no ref_done pulse.
REQ-045 init_start and ref_req rise in the same cycle -> an init sequence with 8 REF commands runs, with a single ref_done.
